// File: rtl/di_terminal_router.sv
// Routes the di_* bus from HostInterface to one of NUM_TERMS terminals by address.
// Define DI_ROUTER_WATCHDOG_EN to force completion of transfers to a terminal that never becomes ready.
module di_terminal_router #(
    parameter int          NUM_TERMS      = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] UNMAPPED_DATA  = 16'h0000
) (
    input  logic                      ifclk,
    input  logic                      reset,
    input  logic [15:0]               di_term_addr,
    input  logic                      di_read_mode,
    input  logic                      di_write_mode,
    input  logic                      di_read_req,
    input  logic                      di_read,
    input  logic                      di_write,
    output logic [15:0]               di_reg_datao,
    output logic                      di_read_rdy,
    output logic                      di_write_rdy,
    output logic [15:0]               di_transfer_status,
    input  logic [16*NUM_TERMS-1:0]   term_addr_table,
    input  logic [16*NUM_TERMS-1:0]   t_reg_datao,
    input  logic [NUM_TERMS-1:0]      t_read_rdy,
    input  logic [NUM_TERMS-1:0]      t_write_rdy,
    input  logic [16*NUM_TERMS-1:0]   t_transfer_status,
    output logic [NUM_TERMS-1:0]      t_sel,
    output logic [NUM_TERMS-1:0]      t_read_req,
    output logic [NUM_TERMS-1:0]      t_read,
    output logic [NUM_TERMS-1:0]      t_write,
    output logic                      timeout_flag
);

    if (NUM_TERMS < 1 || NUM_TERMS > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("di_terminal_router: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, UNMAPPED, TIMEOUT} state_t;

    state_t                 state, next_state;
    logic                   mode_any, both_modes, start, dual_q, dual_eff;
    logic                   hit, rdy_mode, wd_expired;
    logic [NUM_TERMS-1:0]   hit_vec;
    logic [15:0]            sel_data, sel_status, status_hold;
    logic                   sel_rrdy, sel_wrdy;

    assign mode_any   = di_read_mode | di_write_mode;
    assign both_modes = di_read_mode & di_write_mode;
    assign start      = (state == IDLE) & mode_any;
    assign dual_eff   = dual_q | both_modes;

    // Descending scan so the lowest matching port is the one left standing.
    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        for (int i = NUM_TERMS - 1; i >= 0; i--) begin
            if (term_addr_table[16*i +: 16] == di_term_addr) begin
                hit_vec    = '0;
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data   = '0;
        sel_status = '0;
        sel_rrdy   = 1'b0;
        sel_wrdy   = 1'b0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (t_sel[i]) begin
                sel_data   = sel_data   | t_reg_datao[16*i +: 16];
                sel_status = sel_status | t_transfer_status[16*i +: 16];
                sel_rrdy   = sel_rrdy   | t_read_rdy[i];
                sel_wrdy   = sel_wrdy   | t_write_rdy[i];
            end
        end
    end

    assign rdy_mode = di_read_mode ? sel_rrdy : sel_wrdy;

`ifdef DI_ROUTER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (start || rdy_mode)
            wd_cnt <= '0;
        else if (state == ACTIVE)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset)
            timeout_flag <= 1'b0;
        else if (next_state == TIMEOUT)
            timeout_flag <= 1'b1;
    end
`else
    assign wd_expired   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge ifclk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (mode_any) next_state = hit ? ACTIVE : UNMAPPED;
            ACTIVE: begin
                if (!mode_any)
                    next_state = IDLE;
                else if (!rdy_mode && wd_expired)
                    next_state = TIMEOUT;
            end
            UNMAPPED: if (!mode_any) next_state = IDLE;
            TIMEOUT:  if (!mode_any) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Selection and dual-mode flag are captured once per transaction.
    always_ff @(posedge ifclk or posedge reset) begin
        if (reset) begin
            t_sel       <= '0;
            dual_q      <= 1'b0;
            status_hold <= '0;
        end else begin
            if (start)
                t_sel <= hit_vec;
            else if (next_state == IDLE)
                t_sel <= '0;
            dual_q <= (next_state == IDLE) ? 1'b0 : (dual_q | both_modes);
            if (state != IDLE)
                status_hold <= di_transfer_status;
        end
    end

    always_comb begin
        di_reg_datao       = '0;
        di_read_rdy        = 1'b0;
        di_write_rdy       = 1'b0;
        di_transfer_status = status_hold;
        case (state)
            ACTIVE: begin
                di_reg_datao       = sel_data;
                di_read_rdy        = sel_rrdy;
                di_write_rdy       = sel_wrdy;
                di_transfer_status = sel_status | {6'b0, dual_eff, 9'b0};
            end
            UNMAPPED: begin
                di_reg_datao       = UNMAPPED_DATA;
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_transfer_status = 16'h0100 | {6'b0, dual_eff, 9'b0};
            end
            TIMEOUT: begin
                di_reg_datao       = 16'hDEAD;
                di_read_rdy        = 1'b1;
                di_write_rdy       = 1'b1;
                di_transfer_status = 16'h0200 | sel_status;
            end
            default: ;
        endcase
    end

    // t_sel is zero outside ACTIVE/TIMEOUT, so these gates also cover the idle and unmapped cases.
    assign t_read_req = t_sel & {NUM_TERMS{di_read_req}};
    assign t_read     = t_sel & {NUM_TERMS{di_read}};
    assign t_write    = t_sel & {NUM_TERMS{di_write & ~dual_eff}};

endmodule

// File: tb/tb_di_terminal_router.sv
// Bench for di_terminal_router: transaction-level model compared every negedge plus directed literal checks.
// Watchdog scenario depends on DI_ROUTER_WATCHDOG_EN.
module tb_di_terminal_router;
    localparam int          NT  = 4;
    localparam int          TO  = 8;
    localparam logic [15:0] UNM = 16'h0BAD;
`ifdef DI_ROUTER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic              ifclk = 1'b0;
    logic              reset = 1'b0;
    logic [15:0]       di_term_addr = '0;
    logic              di_read_mode = 0, di_write_mode = 0;
    logic              di_read_req = 0, di_read = 0, di_write = 0;
    logic [15:0]       di_reg_datao, di_transfer_status;
    logic              di_read_rdy, di_write_rdy, timeout_flag;
    logic [16*NT-1:0]  term_addr_table, t_reg_datao, t_transfer_status;
    logic [NT-1:0]     t_read_rdy, t_write_rdy;
    logic [NT-1:0]     t_sel, t_read_req, t_read, t_write;

    int n_tests = 0;
    int n_fail  = 0;

    di_terminal_router #(.NUM_TERMS(NT), .TIMEOUT_CYCLES(TO), .UNMAPPED_DATA(UNM)) dut (
        .ifclk(ifclk), .reset(reset), .di_term_addr(di_term_addr),
        .di_read_mode(di_read_mode), .di_write_mode(di_write_mode),
        .di_read_req(di_read_req), .di_read(di_read), .di_write(di_write),
        .di_reg_datao(di_reg_datao), .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
        .di_transfer_status(di_transfer_status), .term_addr_table(term_addr_table),
        .t_reg_datao(t_reg_datao), .t_read_rdy(t_read_rdy), .t_write_rdy(t_write_rdy),
        .t_transfer_status(t_transfer_status), .t_sel(t_sel), .t_read_req(t_read_req),
        .t_read(t_read), .t_write(t_write), .timeout_flag(timeout_flag)
    );

    always #5 ifclk = ~ifclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_in, m_to, m_dual, m_flag;
    int          m_port, m_wait;
    logic [15:0] m_last;

    function automatic int lookup(input logic [15:0] a);
        for (int i = 0; i < NT; i++)
            if (term_addr_table[16*i +: 16] == a) return i;
        return -1;
    endfunction

    function automatic logic [NT-1:0] onehot(input int p);
        logic [NT-1:0] v;
        v = '0;
        if (p >= 0) v[p] = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] exp_status();
        logic [15:0] s;
        if (!m_in) return m_last;
        if (m_port < 0)  s = 16'h0100;
        else if (m_to)   s = 16'h0200 | t_transfer_status[16*m_port +: 16];
        else             s = t_transfer_status[16*m_port +: 16];
        if (m_dual || (di_read_mode && di_write_mode)) s = s | 16'h0200;
        return s;
    endfunction

    function automatic bit port_ready();
        return di_read_mode ? t_read_rdy[m_port] : t_write_rdy[m_port];
    endfunction

    always @(posedge ifclk or posedge reset) begin
        if (reset) begin
            m_in <= 0; m_to <= 0; m_dual <= 0; m_flag <= 0;
            m_port <= -1; m_wait <= 0; m_last <= '0;
        end else if (!m_in) begin
            if (di_read_mode || di_write_mode) begin
                m_in <= 1; m_to <= 0; m_wait <= 0;
                m_port <= lookup(di_term_addr);
                m_dual <= di_read_mode && di_write_mode;
            end
        end else if (!(di_read_mode || di_write_mode)) begin
            m_last <= exp_status();
            m_in   <= 0;
        end else begin
            m_last <= exp_status();
            m_dual <= m_dual || (di_read_mode && di_write_mode);
            if (WD && m_port >= 0 && !m_to) begin
                if (port_ready()) m_wait <= 0;
                else begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 >= TO) begin m_to <= 1; m_flag <= 1; end
                end
            end
        end
    end

    always @(negedge ifclk) begin : cmp
        logic [15:0]   e_data;
        logic          e_rr, e_wr;
        logic [NT-1:0] e_sel;
        bit            dual;
        if (!reset) begin
            dual   = m_dual || (di_read_mode && di_write_mode);
            e_data = '0; e_rr = 0; e_wr = 0; e_sel = '0;
            if (m_in && m_port < 0) begin
                e_data = UNM; e_rr = 1; e_wr = 1;
            end else if (m_in && m_to) begin
                e_data = 16'hDEAD; e_rr = 1; e_wr = 1; e_sel = onehot(m_port);
            end else if (m_in) begin
                e_data = t_reg_datao[16*m_port +: 16];
                e_rr   = t_read_rdy[m_port];
                e_wr   = t_write_rdy[m_port];
                e_sel  = onehot(m_port);
            end
            check("m_datao",  di_reg_datao, e_data);
            check("m_rrdy",   16'(di_read_rdy), 16'(e_rr));
            check("m_wrdy",   16'(di_write_rdy), 16'(e_wr));
            check("m_status", di_transfer_status, exp_status());
            check("m_sel",    16'(t_sel), 16'(e_sel));
            check("m_rreq",   16'(t_read_req), 16'(di_read_req ? e_sel : '0));
            check("m_read",   16'(t_read), 16'(di_read ? e_sel : '0));
            check("m_write",  16'(t_write), 16'((di_write && !dual) ? e_sel : '0));
            check("m_flag",   16'(timeout_flag), 16'(m_flag));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ifclk);
            #1;
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < NT; i++) begin
            t_reg_datao[16*i +: 16]       = 16'hA000 | 16'(i);
            t_transfer_status[16*i +: 16] = 16'h0010 + 16'(i);
            term_addr_table[16*i +: 16]   = 16'(i);
        end
        t_read_rdy  = '1;
        t_write_rdy = '1;

        #1 reset = 1'b1;
        #10;
        check("rst_datao", di_reg_datao, 16'h0000);
        check("rst_status", di_transfer_status, 16'h0000);
        check("rst_sel", 16'(t_sel), 16'h0000);
        check("rst_rdy", 16'({di_read_rdy, di_write_rdy}), 16'h0000);
        #3 reset = 1'b0;
        tick(2);

        // read to port 2
        di_term_addr = 16'h0002; di_read_mode = 1;
        tick();
        check("t1_sel", 16'(t_sel), 16'h0004);
        check("t1_data", di_reg_datao, 16'hA002);
        di_read = 1; #1;
        check("t1_read", 16'(t_read), 16'h0004);
        tick(2);
        di_read = 0; di_read_mode = 0;
        tick();
        check("t1_idle_sel", 16'(t_sel), 16'h0000);
        check("t1_idle_status", di_transfer_status, 16'h0012);
        check("t1_idle_rrdy", 16'(di_read_rdy), 16'h0000);

        // duplicate address: lowest port wins, address changes ignored
        term_addr_table[16*1 +: 16] = 16'h0005;
        term_addr_table[16*3 +: 16] = 16'h0005;
        tick();
        di_term_addr = 16'h0005; di_read_mode = 1;
        tick();
        check("t2_sel", 16'(t_sel), 16'h0002);
        di_term_addr = 16'h0000;
        tick(3);
        check("t2_sel_hold", 16'(t_sel), 16'h0002);
        check("t2_data_hold", di_reg_datao, 16'hA001);
        di_read_mode = 0;
        tick();

        // unmapped write
        di_term_addr = 16'h7777; di_write_mode = 1;
        tick();
        di_write = 1; #1;
        check("t3_wrdy", 16'(di_write_rdy), 16'h0001);
        check("t3_status", di_transfer_status, 16'h0100);
        check("t3_twrite", 16'(t_write), 16'h0000);
        check("t3_data", di_reg_datao, UNM);
        tick(2);
        di_write = 0; di_write_mode = 0;
        tick();
        check("t3_idle_status", di_transfer_status, 16'h0100);

        // stalled read on port 1
        t_read_rdy[1] = 1'b0;
        di_term_addr = 16'h0005; di_read_mode = 1;
        tick();
        tick(7);
        check("t4_still_waiting", 16'(di_read_rdy), 16'h0000);
        tick();
`ifdef DI_ROUTER_WATCHDOG_EN
        check("t4_to_data", di_reg_datao, 16'hDEAD);
        check("t4_to_flag", 16'(timeout_flag), 16'h0001);
        check("t4_to_status", di_transfer_status, 16'h0211);
        tick(2);
        di_read_mode = 0;
        tick();
        check("t4_flag_sticky", 16'(timeout_flag), 16'h0001);
        check("t4_sel_cleared", 16'(t_sel), 16'h0000);
`else
        tick(12);
        check("t4_stall_rdy", 16'(di_read_rdy), 16'h0000);
        check("t4_stall_data", di_reg_datao, 16'hA001);
        check("t4_no_flag", 16'(timeout_flag), 16'h0000);
        t_read_rdy[1] = 1'b1; #1;
        check("t4_release_rdy", 16'(di_read_rdy), 16'h0001);
        di_read_mode = 0;
        tick();
`endif
        t_read_rdy = '1;

        // reset mid-transfer
        di_term_addr = 16'h0000; di_read_mode = 1;
        tick();
        check("t5_data", di_reg_datao, 16'hA000);
        #3 reset = 1'b1;
        #1;
        check("t5_rst_data", di_reg_datao, 16'h0000);
        check("t5_rst_rrdy", 16'(di_read_rdy), 16'h0000);
        check("t5_rst_sel", 16'(t_sel), 16'h0000);
        check("t5_rst_flag", 16'(timeout_flag), 16'h0000);
        check("t5_rst_status", di_transfer_status, 16'h0000);
        #2 reset = 1'b0;
        di_read_mode = 0;
        tick();
        di_term_addr = 16'h0002; di_read_mode = 1;
        tick();
        check("t5_fresh_sel", 16'(t_sel), 16'h0004);
        di_read_mode = 0;
        tick();

        // both modes on port 0
        di_term_addr = 16'h0000; di_read_mode = 1; di_write_mode = 1;
        tick();
        di_write = 1; di_read = 1; #1;
        check("t6_twrite", 16'(t_write), 16'h0000);
        check("t6_tread", 16'(t_read), 16'h0001);
        check("t6_status", di_transfer_status, 16'h0210);
        tick();
        di_write_mode = 0;
        tick();
        check("t6_bit9_kept", di_transfer_status, 16'h0210);
        check("t6_twrite_kept", 16'(t_write), 16'h0000);
        di_read_mode = 0; di_read = 0; di_write = 0;
        tick();
        check("t6_idle_sel", 16'(t_sel), 16'h0000);
        check("t6_idle_rrdy", 16'(di_read_rdy), 16'h0000);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1);
    end
endmodule
